// File: rtl/shift_unit_seq_pkg.sv
// Shared encodings for the multicycle shift unit: opcodes, amount-source selects
// and controller states.
package shift_pkg;

   localparam logic [2:0] OP_SLL     = 3'd0;
   localparam logic [2:0] OP_SRL     = 3'd1;
   localparam logic [2:0] OP_SRA     = 3'd2;
   localparam logic [2:0] OP_ROR     = 3'd3;
   localparam logic [2:0] OP_ROL     = 3'd4;
   localparam logic [2:0] OP_PASS_LO = 3'd5;

   localparam logic [1:0] SEL_CONST = 2'b00;
   localparam logic [1:0] SEL_SHAMT = 2'b10;
   localparam logic [1:0] SEL_B     = 2'b11;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // Opcodes 5..7 leave the operand untouched and never iterate
   function automatic logic isPass(input logic [2:0] op);
      return op >= OP_PASS_LO;
   endfunction

endpackage

// File: rtl/shift_unit_seq_amt_sel.sv
// Combinational shift-amount source mux: constant, instruction shamt field or
// the low bits of register B, all reduced to an AMT_W-bit amount.
module shift_amt_sel
   import shift_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int CONST_N = 16
) (
   input  logic [1:0]                  sel,
   input  logic [4:0]                  shamt,
   input  logic [DATA_W-1:0]           b,
   output logic [$clog2(DATA_W)-1:0]   amt
);

   localparam int AMT_W = $clog2(DATA_W);
   localparam logic [AMT_W-1:0] CONST_AMT = AMT_W'(CONST_N % DATA_W);

   // sel=01 is an alias of the constant source, hence the default arm
   always_comb begin
      amt = CONST_AMT;
      if (sel[1] != SEL_CONST[1]) begin
         case (sel)
            SEL_SHAMT: amt = AMT_W'(shamt);
            SEL_B:     amt = AMT_W'(b);
            default:   amt = CONST_AMT;
         endcase
      end
   end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative shift unit: captures operand, opcode and amount on start, then
// shifts by up to STEP positions per cycle until the amount is used up.
module shift_unit_seq
   import shift_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int STEP    = 1,
   parameter int CONST_N = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [1:0]        sel,
   input  logic [4:0]        shamt,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] operand,
   output logic [DATA_W-1:0] result,
   output logic              busy,
   output logic              done
);

   localparam int AMT_W = $clog2(DATA_W);

   state_t             r_state;
   logic [DATA_W-1:0]  r_result;
   logic [2:0]         r_op;
   logic [AMT_W-1:0]   r_rem;
   logic               r_busy;
   logic               r_done;

   logic [AMT_W-1:0]   w_amt;
   logic [AMT_W-1:0]   w_step;
   logic [AMT_W-1:0]   w_remNext;

   shift_amt_sel #(
      .DATA_W  (DATA_W),
      .CONST_N (CONST_N)
   ) u_amtSel (
      .sel   (sel),
      .shamt (shamt),
      .b     (b),
      .amt   (w_amt)
   );

   // Rotates use the complementary shift; s is never 0 while iterating
   function automatic logic [DATA_W-1:0] stepShift(
      input logic [2:0]        stepOp,
      input logic [DATA_W-1:0] v,
      input logic [AMT_W-1:0]  s
   );
      logic [AMT_W:0] inv;
      inv = (AMT_W+1)'(DATA_W) - {1'b0, s};
      case (stepOp)
         OP_SLL:  return v << s;
         OP_SRL:  return v >> s;
         OP_SRA:  return $unsigned($signed(v) >>> s);
         OP_ROR:  return (v >> s) | (v << inv);
         OP_ROL:  return (v << s) | (v >> inv);
         default: return v;
      endcase
   endfunction

   always_comb begin
      w_step = AMT_W'(STEP);
      if (int'(r_rem) < STEP) begin
         w_step = r_rem;
      end
      w_remNext = r_rem - w_step;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_result <= '0;
         r_op     <= OP_SLL;
         r_rem    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_result <= operand;
                  r_op     <= op;
                  r_rem    <= isPass(op) ? '0 : w_amt;
                  r_busy   <= 1'b1;
                  if (isPass(op) || (w_amt == '0)) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               r_result <= stepShift(r_op, r_result, w_step);
               r_rem    <= w_remNext;
               if (w_remNext == '0) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign result = r_result;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Multicycle, parametrised shift unit for the datapath. It merges shift-amount source selection (instruction shamt field, register B low bits, or a fixed constant) with an iterative shifter. The shifter performs SLL/SRL/SRA/ROR/ROL at up to STEP bit positions per cycle under a start/busy/done handshake. It sits between the register-file operand latches and the ALUOut/write-back mux, and is driven by the control FSM.

## Interface
- DATA_W, 32: operand/result width, power of two ≥ 8.
- STEP, 1: max bit positions shifted per cycle, 1..DATA_W.
- CONST_N, 16: constant amount selected when sel[1]=0.
- AMT_W, $clog2(DATA_W): amount width (derived, not overridden).
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  0=SLL, 1=SRL, 2=SRA, 3=ROR, 4=ROL, 5..7=pass-through.
- sel  in  2  amount source: 0x=CONST_N, 10=shamt, 11=b[AMT_W-1:0].
- shamt  in  5  instruction field [10:6].
- b  in  DATA_W  register B operand, amount source only.
- operand  in  DATA_W  value to shift.
- result  out  DATA_W  shifted value, registered.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse, result valid.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - Latch operand into result.
  - Latch op.
  - Latch amount into rem.
  - Go to SHIFT if rem≠0, else DONE.
- Amount is captured only at E0.
  - shamt is zero-extended or truncated to AMT_W.
  - CONST_N is taken mod DATA_W.
  - op 5..7 forces rem=0.
- SHIFT, each edge:
  - s = min(rem, STEP); result ← op(result, s); rem ← rem − s.
  - Go to DONE when rem − s = 0.
- SRA replicates result[DATA_W-1] from the current register value each step. The final value equals a single-step arithmetic shift.
- ROR/ROL are circular over DATA_W; amounts are already < DATA_W.
- DONE: done=1 for exactly one cycle, then IDLE.
- result holds its value in IDLE until the next accepted start.
- start in SHIFT/DONE is ignored: not queued, no effect on the operation in flight.
- sel, op, shamt, b and operand may change freely after E0 without effect.

## Timing
- Reset, synchronous, applied in any state:
  - Next cycle: state=IDLE, result=0, rem=0, busy=0, done=0.
  - An in-flight operation is discarded and no done is emitted.
  - start coincident with reset is ignored.
- Latency: done is high in the cycle ceil(n/STEP)+1 cycles after the start cycle, where n is the effective amount. With n=0 or pass-through, done is high in the cycle immediately after the start cycle.
- busy rises in the cycle after E0 and falls in the cycle after done.
- Back-to-back: start may be asserted in the cycle done is high. It is sampled one edge later, in IDLE, so the minimum issue interval is latency+1.
- No combinational path from inputs to outputs.

## Structure
- Package shift_pkg holds:
  - op encodings: OP_SLL..OP_ROL, OP_PASS range.
  - sel encodings: SEL_CONST, SEL_SHAMT, SEL_B.
  - typedef state_t {IDLE, SHIFT, DONE}.
- One sub-module, shift_amt_sel: combinational amount-source mux (sel, shamt, b → AMT_W amount). It is the generalised replacement for the current fixed-width selector.
- The step shifter (op, value, s → value) is a function inside shift_unit_seq, not a separate module.

## Test plan
- DATA_W=32, STEP=1, op=SLL, sel=00, operand=0x00000001, start → result=0x00010000; done exactly 17 cycles after the start cycle; busy high 17 cycles.
- STEP=4, op=SRA, sel=11, b=0x00000024 (amount 4), operand=0x80000000 → result=0xF8000000; done 2 cycles after start.
- STEP=8, op=ROR, sel=10, shamt=8, operand=0x12345678 → 0x78123456. Repeat with op=ROL → 0x34567812. Each done after 2 cycles.
- Amount 0 (sel=10, shamt=0) and op=5 with any amount, operand=0xDEADBEEF → result=0xDEADBEEF, done in the cycle after start.
- STEP=1, SRL by 31 of 0xFFFFFFFF:
  - start pulsed again mid-operation → ignored; result=0x00000001, single done pulse.
  - Second run: reset pulsed at cycle 10 → next cycle result=0, busy=0, no done.
- Back-to-back: start held high continuously with SLL by 1 and STEP=1 → done every 3 cycles, each result the new operand shifted once.
